// File: rtl/client_queue_if.sv
// client_queue_if: sensor and teller inputs plus queue status outputs of client_queue_mgr
interface client_queue_if #(
  parameter int CNT_W = 4,
  parameter int T_W   = 3,
  parameter int WT_W  = 8
);
  logic             sig_end;
  logic             sig_front;
  logic [T_W-1:0]   tcount;
  logic [CNT_W-1:0] pcount;
  logic [WT_W-1:0]  wtime;
  logic             wtime_valid;
  logic             empty_flag;
  logic             full_flag;
  logic             overflow_err;
  logic             underflow_err;
  logic             tcount_err;
  modport master (
    output sig_end, sig_front, tcount,
    input  pcount, wtime, wtime_valid, empty_flag, full_flag, overflow_err, underflow_err, tcount_err
  );
  modport slave (
    input  sig_end, sig_front, tcount,
    output pcount, wtime, wtime_valid, empty_flag, full_flag, overflow_err, underflow_err, tcount_err
  );
endinterface

// File: rtl/client_queue_mgr.sv
// client_queue_mgr: debounced queue occupancy counter with sequential wait-time divider
module client_queue_mgr #(
  parameter int CNT_W       = 4,
  parameter int MAX_CLIENTS = 15,
  parameter int T_W         = 3,
  parameter int SVC_TIME    = 3,
  parameter int WT_W        = 8,
  parameter int DEBOUNCE    = 4
) (
  input  logic          clk,
  input  logic          reset,
  client_queue_if.slave q
);
  localparam int DB_W = $clog2(DEBOUNCE + 1);
  localparam int BC_W = $clog2(WT_W + 1);
  localparam logic [CNT_W-1:0] MAXC = CNT_W'(MAX_CLIENTS);
  typedef enum logic [1:0] {IDLE, LOAD, DIV, DONE} state_t;
  logic [1:0] raw, sync_q, lvl_q, lvl_d, pulse_q, pulse_d;
  logic [1:0][DB_W-1:0] stab_q, stab_d;
  logic up, dn, full, empty;
  logic [CNT_W-1:0] pcount_q, pcount_d;
  logic ovf_q, ovf_d, unf_q, unf_d;
  state_t state_q;
  logic [T_W-1:0] tcount_q, op_t_q, rem_q;
  logic [CNT_W-1:0] op_p_q;
  logic [WT_W-1:0] num_q, wtime_q, numer;
  logic [BC_W-1:0] bit_q;
  logic valid_q, changed, sub;
  logic [T_W:0] rem_sh;
  // index 0 is the rear (arrival) sensor, index 1 the front (departure) sensor
  assign raw = {q.sig_front, q.sig_end};
  always_comb begin
    lvl_d = lvl_q;
    stab_d = '0;
    for (int i = 0; i < 2; i++) begin
      stab_d[i] = sync_q[i] != lvl_q[i] ? stab_q[i] + DB_W'(1) : '0;
      lvl_d[i] = stab_d[i] == DB_W'(DEBOUNCE) ? sync_q[i] : lvl_q[i];
      stab_d[i] = stab_d[i] == DB_W'(DEBOUNCE) ? '0 : stab_d[i];
    end
    pulse_d = lvl_d & ~lvl_q;
  end
  assign up = pulse_q[0];
  assign dn = pulse_q[1];
  assign full = pcount_q == MAXC;
  assign empty = pcount_q == '0;
  always_comb begin
    ovf_d = up & ~dn & full;
    unf_d = dn & ~up & empty;
    pcount_d = (up & ~dn & ~full) ? pcount_q + CNT_W'(1) :
               (dn & ~up & ~empty) ? pcount_q - CNT_W'(1) : pcount_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      lvl_q <= '0;
      stab_q <= '0;
      pulse_q <= '0;
      pcount_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      sync_q <= raw;
      lvl_q <= lvl_d;
      stab_q <= stab_d;
      pulse_q <= pulse_d;
      pcount_q <= pcount_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end
  assign changed = {pcount_q, tcount_q} != {op_p_q, op_t_q};
  assign rem_sh = {rem_q, num_q[WT_W-1]};
  assign sub = rem_sh >= {1'b0, op_t_q};
  assign numer = WT_W'(SVC_TIME * (int'(pcount_q) + int'(tcount_q) - 1));
  // num_q holds the numerator and shifts the quotient in from the LSB; wtime only moves in DONE
  always_ff @(posedge clk) begin
    tcount_q <= q.tcount;
    if (reset) begin
      state_q <= LOAD;
      wtime_q <= '0;
      valid_q <= 1'b0;
      op_p_q <= '0;
      op_t_q <= '0;
      num_q <= '0;
      rem_q <= '0;
      bit_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (changed) begin
          state_q <= LOAD;
          valid_q <= 1'b0;
        end
        LOAD: begin
          op_p_q <= pcount_q;
          op_t_q <= tcount_q;
          rem_q <= '0;
          bit_q <= '0;
          valid_q <= 1'b0;
          num_q <= tcount_q == '0 ? '1 : pcount_q == '0 ? '0 : numer;
          state_q <= (tcount_q == '0 || pcount_q == '0) ? DONE : DIV;
        end
        DIV: if (changed) state_q <= LOAD;
        else begin
          rem_q <= sub ? T_W'(rem_sh - {1'b0, op_t_q}) : rem_sh[T_W-1:0];
          num_q <= {num_q[WT_W-2:0], sub};
          bit_q <= bit_q + BC_W'(1);
          if (bit_q == BC_W'(WT_W - 1)) state_q <= DONE;
        end
        DONE: begin
          wtime_q <= num_q;
          valid_q <= ~changed;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign q.pcount = pcount_q;
  assign q.wtime = wtime_q;
  assign q.wtime_valid = valid_q;
  assign q.empty_flag = empty;
  assign q.full_flag = full;
  assign q.overflow_err = ovf_q;
  assign q.underflow_err = unf_q;
  assign q.tcount_err = tcount_q == '0;
endmodule

// File: tb/tb_client_queue_mgr.sv
// tb_client_queue_mgr: directed stimulus with a behavioural queue model checked every cycle
module tb_client_queue_mgr;
  localparam int D = 4, MAXC = 15, SVC = 3;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0, errors = 0;
  bit started = 0;
  client_queue_if #(.CNT_W(4), .T_W(3), .WT_W(8)) q();
  client_queue_mgr dut (.clk(clk), .reset(reset), .q(q));
  always #5 clk = ~clk;
  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  function automatic int wt(int p, int t);
    return t == 0 ? 255 : p == 0 ? 0 : SVC * (p + t - 1) / t;
  endfunction
  // model: a sensor level flips once the last D synchronised samples all agree
  logic [D-1:0] he = '0, hf = '0;
  bit le, lf, pe, pf, ovm, unm, rst_m;
  int pm = 0, tm = 0, prev_p = 0, prev_t = 0;
  always @(posedge clk) begin
    bit nle, nlf;
    tm = int'(q.tcount);
    rst_m = reset;
    if (reset) begin
      he = '0; hf = '0; le = 0; lf = 0; pe = 0; pf = 0; pm = 0; ovm = 0; unm = 0;
    end else begin
      ovm = pe && !pf && pm == MAXC;
      unm = pf && !pe && pm == 0;
      if (pe && !pf && pm < MAXC) pm++;
      else if (pf && !pe && pm > 0) pm--;
      nle = (&he) ? 1'b1 : (|he) ? le : 1'b0;
      nlf = (&hf) ? 1'b1 : (|hf) ? lf : 1'b0;
      pe = nle && !le;
      pf = nlf && !lf;
      le = nle;
      lf = nlf;
      he = {he[D-2:0], q.sig_end};
      hf = {hf[D-2:0], q.sig_front};
    end
  end
  logic [7:0] last_wt = '0;
  always @(negedge clk) if (started) begin
    chk("pcount", int'(q.pcount), pm);
    chk("empty_flag", int'(q.empty_flag), int'(pm == 0));
    chk("full_flag", int'(q.full_flag), int'(pm == MAXC));
    chk("overflow_err", int'(q.overflow_err), int'(ovm));
    chk("underflow_err", int'(q.underflow_err), int'(unm));
    chk("tcount_err", int'(q.tcount_err), int'(tm == 0));
    if (rst_m) begin
      chk("reset_wtime", int'(q.wtime), 0);
      chk("reset_valid", int'(q.wtime_valid), 0);
    end else begin
      if (q.wtime_valid) chk("wtime", int'(q.wtime), wt(prev_p, prev_t));
      else if (q.wtime != last_wt) chk("wtime_hold", int'(q.wtime), int'(last_wt));
    end
    prev_p = pm;
    prev_t = tm;
    last_wt = q.wtime;
  end
  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic wait_valid(string name, int lim);
    int n = 0;
    step(2);
    while (!q.wtime_valid && n < lim) begin
      step(1);
      n++;
    end
    chk({name, "_valid_timeout"}, int'(q.wtime_valid), 1);
  endtask
  task automatic pulse(bit e, bit f, int hi, int lo, output int n_ovf, output int n_unf);
    n_ovf = 0;
    n_unf = 0;
    q.sig_end = e;
    q.sig_front = f;
    for (int i = 0; i < hi + lo; i++) begin
      if (i == hi) begin
        q.sig_end = 0;
        q.sig_front = 0;
      end
      step(1);
      n_ovf += int'(q.overflow_err);
      n_unf += int'(q.underflow_err);
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int no, nu;
    q.sig_end = 0;
    q.sig_front = 0;
    q.tcount = 2;
    @(posedge clk);
    started = 1;
    step(2);
    reset = 0;
    step(1);
    chk("t1_valid_r1", int'(q.wtime_valid), 0);
    step(1);
    chk("t1_valid_r2", int'(q.wtime_valid), 1);
    chk("t1_wtime", int'(q.wtime), 0);
    chk("t1_pcount", int'(q.pcount), 0);
    chk("t1_empty", int'(q.empty_flag), 1);
    for (int i = 1; i <= 5; i++) begin
      q.sig_end = 1;
      step(5);
      chk("t2_before_step", int'(q.pcount), i - 1);
      step(1);
      chk("t2_step", int'(q.pcount), i);
      q.sig_end = 0;
      step(6);
    end
    step(4);
    chk("t2_valid_early", int'(q.wtime_valid), 0);
    step(1);
    chk("t2_valid", int'(q.wtime_valid), 1);
    chk("t2_wtime", int'(q.wtime), 9);
    q.sig_end = 1;
    step(3);
    q.sig_end = 0;
    step(10);
    chk("t3_glitch", int'(q.pcount), 5);
    pulse(1, 0, 20, 10, no, nu);
    chk("t3_long_high", int'(q.pcount), 6);
    for (int i = 0; i < 9; i++) pulse(1, 0, 6, 6, no, nu);
    chk("t4_full_count", int'(q.pcount), 15);
    chk("t4_full_flag", int'(q.full_flag), 1);
    pulse(1, 0, 6, 6, no, nu);
    chk("t4_overflow_cycles", no, 1);
    chk("t4_pcount_hold", int'(q.pcount), 15);
    q.tcount = 7;
    wait_valid("t4", 30);
    chk("t4_wtime", int'(q.wtime), 9);
    q.tcount = 2;
    for (int i = 0; i < 15; i++) pulse(0, 1, 6, 6, no, nu);
    chk("t5_drained", int'(q.pcount), 0);
    pulse(0, 1, 6, 6, no, nu);
    chk("t5_underflow_cycles", nu, 1);
    chk("t5_pcount_hold", int'(q.pcount), 0);
    pulse(1, 1, 6, 6, no, nu);
    chk("t5_aligned_ovf", no, 0);
    chk("t5_aligned_unf", nu, 0);
    chk("t5_aligned_pcount", int'(q.pcount), 0);
    pulse(1, 0, 6, 6, no, nu);
    pulse(1, 1, 6, 6, no, nu);
    chk("t5_aligned_nonempty", int'(q.pcount), 1);
    wait_valid("t6_pre", 30);
    chk("t6_wtime_t2", int'(q.wtime), 3);
    q.tcount = 0;
    step(1);
    chk("t6_tcount_err", int'(q.tcount_err), 1);
    step(2);
    chk("t6_special_early", int'(q.wtime_valid), 0);
    step(1);
    chk("t6_special_valid", int'(q.wtime_valid), 1);
    chk("t6_wtime_ff", int'(q.wtime), 255);
    q.tcount = 3;
    step(4);
    q.tcount = 1;
    step(11);
    chk("t6_restart_early", int'(q.wtime_valid), 0);
    step(1);
    chk("t6_restart_valid", int'(q.wtime_valid), 1);
    chk("t6_restart_wtime", int'(q.wtime), 3);
    q.tcount = 2;
    step(4);
    reset = 1;
    step(1);
    chk("t6_rst_pcount", int'(q.pcount), 0);
    chk("t6_rst_wtime", int'(q.wtime), 0);
    chk("t6_rst_valid", int'(q.wtime_valid), 0);
    chk("t6_rst_empty", int'(q.empty_flag), 1);
    chk("t6_rst_full", int'(q.full_flag), 0);
    reset = 0;
    step(2);
    chk("t6_post_valid", int'(q.wtime_valid), 1);
    chk("t6_post_wtime", int'(q.wtime), 0);
    step(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
